// File: rtl/ser_frame_loader_pkg.sv
// Shared types and constants for the serial frame loader.
// Holds the frame FSM states, the output buffer depth and the default sync word.
package ser_frame_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        LEN  = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam int BUF_DEPTH = 2;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/ser_frame_loader_ser2par.sv
// ser2par: single-bit serial to LENGTH-bit parallel deserializer.
// Ports: clock, reset (async, active-high), direct (0 = LSB first,
// 1 = MSB first), ivalid/idata (accepted bit), ovalid/odata (one-cycle
// word pulse after the LENGTH-th bit), pending (partial word held).
module ser2par
    import ser_frame_loader_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              direct,
    input  logic              ivalid,
    input  logic              idata,
    output logic              ovalid,
    output logic [LENGTH-1:0] odata,
    output logic              pending
);

    localparam int CW = $clog2(LENGTH);

    logic [CW-1:0]     cnt;
    logic [LENGTH-1:0] shreg;
    logic [LENGTH-1:0] shnext;
    logic              last;

    // LSB-first shifts in at the top so the first bit ends at bit 0.
    always_comb begin
        shnext = direct ? {shreg[LENGTH-2:0], idata}
                        : {idata, shreg[LENGTH-1:1]};
        last   = (cnt == CW'(LENGTH - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            shreg  <= '0;
            ovalid <= 1'b0;
            odata  <= '0;
        end else begin
            ovalid <= ivalid & last;
            if (ivalid) begin
                shreg <= shnext;
                cnt   <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    odata <= shnext;
                end
            end
        end
    end

    assign pending = (cnt != '0);

endmodule

// File: rtl/ser_frame_loader.sv
// ser_frame_loader: turns a framed serial stream (sync, base, length, data)
// into addressed write requests through a 2-entry output buffer.
// Ports: clock, reset (async, active-high), direct (bit order),
// sin_valid/sin_data/sin_ready (serial in), wr_valid/wr_ready/wr_addr/
// wr_data (write out), busy, frame_done and err_sync (one-cycle pulses).
module ser_frame_loader
    import ser_frame_loader_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC  = WIDTH'(DEFAULT_SYNC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             direct,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             frame_done,
    output logic             err_sync
);

    state_t state;
    state_t state_nx;

    logic             word_valid;
    logic [WIDTH-1:0] word;
    logic             bits_pending;

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] len;
    logic [WIDTH-1:0] idx;
    logic             last_word;

    logic [2*WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    ser2par #(
        .LENGTH (WIDTH)
    ) u_ser2par (
        .clock   (clock),
        .reset   (reset),
        .direct  (direct),
        .ivalid  (sin_valid & sin_ready),
        .idata   (sin_data),
        .ovalid  (word_valid),
        .odata   (word),
        .pending (bits_pending)
    );

    assign last_word = (idx == len);
    assign full      = (count == 2'(BUF_DEPTH));
    assign empty     = (count == 2'd0);
    assign push      = word_valid & (state == DATA);
    assign pop       = wr_valid & wr_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (word_valid && word == SYNC) state_nx = ADDR;
            ADDR: if (word_valid) state_nx = LEN;
            LEN:  if (word_valid) state_nx = DATA;
            DATA: if (word_valid && last_word) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        frame_done = 1'b0;
        err_sync   = 1'b0;
        if (word_valid) begin
            frame_done = (state == DATA) & last_word;
            err_sync   = (state == IDLE) & (word != SYNC);
        end
    end

    // Header registers; idx wraps with the address arithmetic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base <= '0;
            len  <= '0;
            idx  <= '0;
        end else if (word_valid) begin
            case (state)
                ADDR: begin
                    base <= word;
                    idx  <= '0;
                end
                LEN:  len <= word;
                DATA: idx <= idx + WIDTH'(1);
                default: ;
            endcase
        end
    end

    // Output buffer: entry = {address, data}
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= {base + idx, word};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign wr_valid  = ~empty;
    assign wr_addr   = buf_mem[rd_ptr][2*WIDTH-1:WIDTH];
    assign wr_data   = buf_mem[rd_ptr][WIDTH-1:0];
    assign sin_ready = ~full;
    assign busy      = (state != IDLE) | bits_pending | ~empty;

endmodule
